uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART byte transmitter between N byte-stream requesters. It accepts bytes over per-requester valid/ready handshakes and issues them one at a time to the transmitter's write-enable/busy interface. It supports message locking, so a multi-byte message from one requester is never interleaved with bytes from another. It sits between the on-chip message sources and the UART transmit block, in the transmitter's clock domain.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_sched_rr_arbiter.sv | 36 +++
 rtl/uart_tx_sched.sv | 156 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit scheduler.
// State encoding, byte width and idle data value.
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [BYTE_W-1:0] IDLE_DATA = 8'hFF;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker.
// Searches masked requests starting at the pointer index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_mask,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx
);

    logic [N-1:0]  elig;
    logic          found;
    logic [PW-1:0] j;

    assign elig = i_req & i_mask;

    // First eligible index at or after the pointer, wrapping.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = PW'((int'(i_ptr) + i) % N);
            if (!found && elig[j]) begin
                found    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter.
// Message locking keeps multi-byte messages contiguous.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N            = 4,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LT_W         = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N-1:0]        i_req_valid,
    input  logic [BYTE_W*N-1:0] i_req_data,
    input  logic [N-1:0]        i_req_last,
    output logic [N-1:0]        o_req_ready,
    output logic [BYTE_W-1:0]   o_tx_data,
    output logic                o_tx_we,
    input  logic                i_tx_busy,
    output logic [N-1:0]        o_grant,
    output logic                o_lock_drop
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [1:0]        state;
    logic              locked;
    logic [PW-1:0]     lock_idx;
    logic [N-1:0]      lock_oh;
    logic [N-1:0]      cur_oh;
    logic [PW-1:0]     ptr;
    logic [LT_W-1:0]   lt_cnt;
    logic              drop_q;
    logic [BYTE_W-1:0] tx_data_q;

    logic [N-1:0]      mask;
    logic [N-1:0]      arb_gnt;
    logic [PW-1:0]     arb_idx;
    logic              accept;
    logic [BYTE_W-1:0] sel_data;
    logic              sel_last;
    logic              owner_valid;
    logic              lt_run;
    logic              lt_hit;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + PW'(1);
    endfunction

    assign mask = locked ? lock_oh : '1;

    rr_arbiter #(
        .N  (N),
        .PW (PW)
    ) u_arb (
        .i_req  (i_req_valid),
        .i_mask (mask),
        .i_ptr  (ptr),
        .o_gnt  (arb_gnt),
        .o_idx  (arb_idx)
    );

    assign o_req_ready = (i_rst_n && state == ST_IDLE && !i_tx_busy)
                         ? arb_gnt : '0;
    assign accept      = |o_req_ready;

    // Select the winner's byte and last flag.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (arb_gnt[k]) begin
                sel_data = sel_data | i_req_data[BYTE_W*k +: BYTE_W];
                sel_last = sel_last | i_req_last[k];
            end
        end
    end

    assign owner_valid = |(i_req_valid & lock_oh);
    assign lt_run = (LOCK_TIMEOUT != 0) && (state == ST_IDLE)
                    && locked && !owner_valid;
    assign lt_hit = lt_run
                    && ((lt_cnt + LT_W'(1)) == LT_W'(LOCK_TIMEOUT));

    // Transfer sequencing: accept, strobe, wait busy rise, wait fall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (accept) state <= ST_SEND;
                ST_SEND:  state <= ST_ACK;
                ST_ACK:   if (i_tx_busy) state <= ST_DRAIN;
                ST_DRAIN: if (!i_tx_busy) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Capture accepted byte and its owner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_data_q <= IDLE_DATA;
            cur_oh    <= '0;
        end else if (accept) begin
            tx_data_q <= sel_data;
            cur_oh    <= arb_gnt;
        end
    end

    // Lock ownership, round-robin pointer and timeout drop pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            locked   <= 1'b0;
            lock_idx <= '0;
            lock_oh  <= '0;
            ptr      <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (accept) begin
                if (sel_last) begin
                    locked  <= 1'b0;
                    lock_oh <= '0;
                    ptr     <= inc_ptr(arb_idx);
                end else begin
                    locked   <= 1'b1;
                    lock_oh  <= arb_gnt;
                    lock_idx <= arb_idx;
                end
            end else if (lt_hit) begin
                locked  <= 1'b0;
                lock_oh <= '0;
                drop_q  <= 1'b1;
                ptr     <= inc_ptr(lock_idx);
            end
        end
    end

    // Idle-owner counter; restarts whenever the owner is active.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lt_cnt <= '0;
        end else if (!lt_run || lt_hit) begin
            lt_cnt <= '0;
        end else begin
            lt_cnt <= lt_cnt + LT_W'(1);
        end
    end

    assign o_tx_we     = (state == ST_SEND);
    assign o_tx_data   = tx_data_q;
    assign o_lock_drop = drop_q;
    assign o_grant     = locked ? lock_oh
                       : (state != ST_IDLE) ? cur_oh : '0;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a byte scoreboard.
// Models the transmitter busy window after each write strobe.
module tb_uart_tx_sched;

    localparam int FRAME = 2340;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  o_req_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_we;
    logic        tx_busy;
    logic [3:0]  o_grant;
    logic        o_lock_drop;

    logic        hold_busy;
    logic        tx_ignore;
    int          busy_cnt;

    int          n_vec;
    int          n_err;

    logic [8:0]  src_q [4][$];
    logic [11:0] exp_q [$];

    uart_tx_sched #(
        .N            (4),
        .LOCK_TIMEOUT (10),
        .LT_W         (16)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (o_req_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_we     (o_tx_we),
        .i_tx_busy   (tx_busy),
        .o_grant     (o_grant),
        .o_lock_drop (o_lock_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter: busy for FRAME cycles after each write strobe.
    always @(posedge clk) begin
        if (o_tx_we && !tx_ignore) busy_cnt <= FRAME;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    assign tx_busy = (busy_cnt != 0) || hold_busy;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester sources: present queue heads, pop on handshake.
    initial begin : drv
        logic [3:0] hs;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & o_req_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (hs[k] && src_q[k].size() > 0)
                    void'(src_q[k].pop_front());
                if (src_q[k].size() > 0) begin
                    req_valid[k]       = 1'b1;
                    req_last[k]        = src_q[k][0][8];
                    req_data[8*k +: 8] = src_q[k][0][7:0];
                end else begin
                    req_valid[k]       = 1'b0;
                    req_last[k]        = 1'b0;
                    req_data[8*k +: 8] = 8'h00;
                end
            end
        end
    end

    // Scoreboard: every write strobe must match the next expectation.
    initial begin : sb
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (o_tx_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra_write", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", o_tx_data, e[7:0]);
                    chk("sb_grant", o_grant, e[11:8]);
                end
            end
        end
    end

    task automatic push_src(input int k, input logic last,
                            input logic [7:0] d);
        src_q[k].push_back({last, d});
    endtask

    task automatic push_exp(input logic [3:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic wait_for(input int what, input logic lvl,
                            input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(negedge clk);
            case (what)
                0:       hit = (o_req_ready != 4'b0);
                1:       hit = (o_tx_we === 1'b1);
                default: hit = (tx_busy === lvl);
            endcase
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic settle(input string tag);
        int good;
        good = 0;
        for (int i = 0; i < 30000 && good < 3; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tx_busy && req_valid == 4'b0
                && o_tx_we == 1'b0)
                good++;
            else
                good = 0;
        end
        if (good < 3) chk({tag, "_settle_timeout"}, good, 3);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) src_q[k].delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_vals",
            {o_tx_we, o_tx_data, o_req_ready, o_grant, o_lock_drop},
            {1'b0, 8'hFF, 4'b0000, 4'b0000, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        hold_busy = 1'b0;
        tx_ignore = 1'b0;

        // Single byte from requester 2.
        do_reset();
        push_src(2, 1'b1, 8'hA5);
        push_exp(4'b0100, 8'hA5);
        wait_for(0, 1'b0, "single_ready");
        chk("single_ready", o_req_ready, 4'b0100);
        @(negedge clk);
        chk("single_we", o_tx_we, 1'b1);
        chk("single_ready_1cyc", o_req_ready, 4'b0000);
        chk("single_grant_send", o_grant, 4'b0100);
        wait_for(2, 1'b1, "single_busy_hi");
        chk("single_grant_busy", o_grant, 4'b0100);
        wait_for(2, 1'b0, "single_busy_lo");
        chk("single_grant_drain", o_grant, 4'b0100);
        @(negedge clk);
        chk("single_grant_idle", o_grant, 4'b0000);
        settle("single");

        // Round-robin across all four requesters.
        do_reset();
        push_src(0, 1'b1, 8'h01);
        push_src(0, 1'b1, 8'h05);
        push_src(1, 1'b1, 8'h02);
        push_src(2, 1'b1, 8'h03);
        push_src(3, 1'b1, 8'h04);
        push_exp(4'b0001, 8'h01);
        push_exp(4'b0010, 8'h02);
        push_exp(4'b0100, 8'h03);
        push_exp(4'b1000, 8'h04);
        push_exp(4'b0001, 8'h05);
        settle("rr");

        // Locked 3-byte message from requester 1, requester 0 waiting.
        do_reset();
        push_src(0, 1'b1, 8'h5A);
        push_exp(4'b0001, 8'h5A);
        wait_for(1, 1'b0, "lock_pre_we");
        push_src(1, 1'b0, 8'h11);
        push_src(1, 1'b0, 8'h22);
        push_src(1, 1'b1, 8'h33);
        push_src(0, 1'b1, 8'h44);
        push_exp(4'b0010, 8'h11);
        push_exp(4'b0010, 8'h22);
        push_exp(4'b0010, 8'h33);
        push_exp(4'b0001, 8'h44);
        settle("lock");

        // Lock timeout: requester 3 abandons its message.
        do_reset();
        push_src(3, 1'b0, 8'h77);
        push_exp(4'b1000, 8'h77);
        wait_for(1, 1'b0, "lt_we");
        push_src(0, 1'b1, 8'h88);
        push_exp(4'b0001, 8'h88);
        wait_for(2, 1'b1, "lt_busy_hi");
        wait_for(2, 1'b0, "lt_busy_lo");
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk("lt_hold", {o_lock_drop, o_req_ready, o_grant},
                {1'b0, 4'b0000, 4'b1000});
        end
        @(negedge clk);
        chk("lt_drop", {o_lock_drop, o_req_ready, o_grant},
            {1'b1, 4'b0001, 4'b0000});
        @(negedge clk);
        chk("lt_drop_1cyc", o_lock_drop, 1'b0);
        settle("lt");

        // Transmitter busy across reset: no ready until it clears.
        hold_busy = 1'b1;
        do_reset();
        push_src(1, 1'b1, 8'h99);
        push_exp(4'b0010, 8'h99);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("busy_no_ready", o_req_ready, 4'b0000);
        end
        @(posedge clk);
        #1;
        hold_busy = 1'b0;
        @(negedge clk);
        chk("busy_first_ready", o_req_ready, 4'b0010);
        settle("busy");

        // Reset while waiting in ACK.
        do_reset();
        tx_ignore = 1'b1;
        push_src(2, 1'b0, 8'h3C);
        push_exp(4'b0100, 8'h3C);
        wait_for(1, 1'b0, "rst_we");
        @(negedge clk);
        chk("rst_ack_grant", o_grant, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async",
            {o_tx_we, o_grant, o_tx_data, o_req_ready},
            {1'b0, 4'b0000, 8'hFF, 4'b0000});
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        tx_ignore = 1'b0;
        push_src(1, 1'b1, 8'h21);
        push_src(0, 1'b1, 8'h20);
        push_exp(4'b0001, 8'h20);
        push_exp(4'b0010, 8'h21);
        settle("rst_resume");

        chk("sb_leftover", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
